// File: rtl/icache_pkg.sv
// icache_pkg: shared state encodings, bus widths and pc field positions for the instruction cache
package icache_pkg;
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] MEM_READ = 2'd1;
   localparam logic [1:0] UPDATE   = 2'd2;
   localparam int BLOCK_W    = 128;
   localparam int WORD_W     = 32;
   localparam int MEM_ADDR_W = 28;
   localparam int OFFSET_LSB = 2;
   localparam int INDEX_LSB  = 4;
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays with combinational hit and word select and a single fill port
module icache_line_store
   import icache_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int INDEX_W  = 3,
   parameter int TAG_W    = 25
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [INDEX_W-1:0] rd_index,
   input  logic [TAG_W-1:0]   rd_tag,
   input  logic [1:0]         rd_offset,
   output logic               hit,
   output logic [WORD_W-1:0]  word,
   input  logic               we,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [BLOCK_W-1:0] wr_data
);
   logic [NUM_SETS-1:0] valid;
   logic [TAG_W-1:0]    tag_array  [NUM_SETS];
   logic [BLOCK_W-1:0]  data_array [NUM_SETS];
   logic [BLOCK_W-1:0]  line;

   always_ff @(posedge clock or posedge reset)
      if (reset) valid <= '0;
      else if (we) valid[wr_index] <= 1'b1;

   // tag and data contents survive reset; only valid bits are cleared
   always_ff @(posedge clock)
      if (we) begin
         tag_array[wr_index]  <= wr_tag;
         data_array[wr_index] <= wr_data;
      end

   assign line = data_array[rd_index];
   assign hit  = valid[rd_index] && tag_array[rd_index] == rd_tag;
   assign word = line[{rd_offset, 5'd0} +: WORD_W];
endmodule

// File: rtl/icache_controller.sv
// icache_controller: direct-mapped read-only instruction cache with miss FSM driving a 128-bit block-read port
module icache_controller
   import icache_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int INDEX_W  = 3,
   parameter int TAG_W    = 25
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  read,
   input  logic [31:0]           pc,
   output logic [WORD_W-1:0]     instruction,
   output logic                  busywait,
   output logic                  mem_read,
   output logic [MEM_ADDR_W-1:0] mem_address,
   input  logic [BLOCK_W-1:0]    mem_readdata,
   input  logic                  mem_busywait
);
   logic [1:0]            state;
   logic [MEM_ADDR_W-1:0] miss_addr;
   logic [BLOCK_W-1:0]    fill_block;
   logic                  first_cycle;
   logic [15:0]           miss_count;
   logic                  hit;
   logic [WORD_W-1:0]     word;
   logic                  unused_bits;

   icache_line_store #(.NUM_SETS(NUM_SETS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_store (
      .clock    (clock),
      .reset    (reset),
      .rd_index (pc[INDEX_LSB +: INDEX_W]),
      .rd_tag   (pc[31:INDEX_LSB+INDEX_W]),
      .rd_offset(pc[OFFSET_LSB +: 2]),
      .hit      (hit),
      .word     (word),
      .we       (state == UPDATE),
      .wr_index (miss_addr[INDEX_W-1:0]),
      .wr_tag   (miss_addr[MEM_ADDR_W-1:INDEX_W]),
      .wr_data  (fill_block)
   );

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state       <= IDLE;
         miss_addr   <= '0;
         fill_block  <= '0;
         first_cycle <= 1'b0;
         miss_count  <= '0;
      end else begin
         case (state)
            IDLE:
               if (read && !hit) begin
                  state       <= MEM_READ;
                  miss_addr   <= pc[31:INDEX_LSB];
                  first_cycle <= 1'b1;
                  miss_count  <= miss_count + 16'd1;
               end
            MEM_READ:
               // the entry edge is skipped so memory is guaranteed to have seen mem_read
               if (first_cycle) first_cycle <= 1'b0;
               else if (!mem_busywait) begin
                  fill_block <= mem_readdata;
                  state      <= UPDATE;
               end
            default: state <= IDLE;
         endcase
      end

   assign mem_read    = state == MEM_READ;
   assign mem_address = mem_read ? miss_addr : '0;
   assign busywait    = !reset && (state == IDLE ? read && !hit : 1'b1);
   assign instruction = hit ? word : '0;
   assign unused_bits = ^{pc[1:0], miss_count};
endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: directed checks of hits, misses, conflicts, mid-miss pc change and mid-fill reset
module tb_icache_controller;
   logic         clock = 0;
   logic         reset;
   logic         read;
   logic [31:0]  pc;
   logic [31:0]  instruction;
   logic         busywait;
   logic         mem_read;
   logic [27:0]  mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;
   logic [2:0]   mem_cnt;
   int           errors = 0;
   int           checks = 0;

   icache_controller dut (
      .clock       (clock),
      .reset       (reset),
      .read        (read),
      .pc          (pc),
      .instruction (instruction),
      .busywait    (busywait),
      .mem_read    (mem_read),
      .mem_address (mem_address),
      .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait)
   );

   always #5 clock = ~clock;

   // memory: busy as soon as read rises, block ready after 4 edges of read
   always @(posedge clock)
      if (!mem_read) mem_cnt <= 0;
      else if (mem_cnt < 4) mem_cnt <= mem_cnt + 1;
   assign mem_busywait = mem_read && mem_cnt < 4;
   assign mem_readdata = mem_address == 28'h0 ?
      {32'h00302223, 32'h002081B3, 32'h00506113, 32'h00500093} :
      {mem_address, 4'h3, mem_address, 4'h2, mem_address, 4'h1, mem_address, 4'h0};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 30; i++) begin
         @(negedge clock); #1;
         if (!busywait) break;
      end
      chk("ready", busywait, 0);
   endtask

   initial begin
      reset = 1; read = 0; pc = 0; mem_cnt = 0;
      @(negedge clock); @(negedge clock); #1;
      chk("rst_busy", busywait, 0);
      chk("rst_mread", mem_read, 0);
      chk("rst_maddr", mem_address, 0);
      chk("rst_mcnt", dut.miss_count, 0);
      @(negedge clock); reset = 0;
      // cold miss
      read = 1; pc = 0; #1;
      chk("cold_busy", busywait, 1);
      chk("cold_mread0", mem_read, 0);
      @(negedge clock); #1;
      chk("cold_mread", mem_read, 1);
      chk("cold_maddr", mem_address, 28'h0);
      wait_ready();
      chk("cold_instr", instruction, 32'h00500093);
      chk("cold_mcnt", dut.miss_count, 1);
      // same-line hits
      pc = 4; #1;
      chk("hit4", instruction, 32'h00506113);
      chk("hit4_busy", busywait, 0);
      chk("hit4_mread", mem_read, 0);
      @(negedge clock); pc = 8; #1;
      chk("hit8", instruction, 32'h002081B3);
      chk("hit8_busy", busywait, 0);
      chk("hit8_mread", mem_read, 0);
      @(negedge clock); pc = 32'hC; #1;
      chk("hitC", instruction, 32'h00302223);
      chk("hitC_busy", busywait, 0);
      chk("hitC_mread", mem_read, 0);
      // conflict eviction of index 0
      @(negedge clock); pc = 32'h80; #1;
      chk("conf_busy", busywait, 1);
      @(negedge clock); #1;
      chk("conf_maddr", mem_address, 28'h0000008);
      wait_ready();
      chk("conf_instr", instruction, 32'h00000080);
      chk("conf_gap", mem_read, 0);
      pc = 0; #1;
      chk("refill_busy", busywait, 1);
      @(negedge clock); #1;
      chk("refill_maddr", mem_address, 28'h0);
      wait_ready();
      chk("refill_instr", instruction, 32'h00500093);
      chk("refill_mcnt", dut.miss_count, 3);
      // pc change during MEM_READ
      pc = 32'h10; #1;
      chk("mid_busy", busywait, 1);
      @(negedge clock); #1;
      chk("mid_maddr", mem_address, 28'h1);
      pc = 0;
      @(negedge clock); #1;
      chk("mid_maddr_hold", mem_address, 28'h1);
      wait_ready();
      chk("mid_pc0", instruction, 32'h00500093);
      chk("mid_mcnt", dut.miss_count, 4);
      pc = 32'h10; #1;
      chk("mid_line1_w0", instruction, 32'h00000010);
      chk("mid_line1_busy", busywait, 0);
      pc = 32'h14; #1;
      chk("mid_line1_w1", instruction, 32'h00000011);
      // reset two cycles into MEM_READ
      pc = 32'h20; #1;
      chk("rf_busy", busywait, 1);
      @(negedge clock); @(negedge clock); #1;
      chk("rf_mread_pre", mem_read, 1);
      reset = 1; #1;
      chk("rf_mread", mem_read, 0);
      chk("rf_busy0", busywait, 0);
      chk("rf_mcnt", dut.miss_count, 0);
      @(negedge clock); reset = 0; pc = 0; #1;
      chk("rf_cold_busy", busywait, 1);
      @(negedge clock); #1;
      chk("rf_cold_maddr", mem_address, 28'h0);
      wait_ready();
      chk("rf_cold_instr", instruction, 32'h00500093);
      chk("rf_cold_mcnt", dut.miss_count, 1);
      // idle with random pc
      read = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); pc = $urandom; #1;
         chk("idle_busy", busywait, 0);
         chk("idle_mread", mem_read, 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
Direct-mapped instruction cache sitting between the fetch stage and `instruction_memory`. It is the requesting end of the 128-bit block-read interface. On a fetch hit it returns the 32-bit word with no stall. On a miss it raises busywait to the pipeline, issues a block read (read, 28-bit block address), waits on the memory's busywait, fills the line and then resumes.

Parameters:
NUM_SETS, 8, number of cache lines; power of two
INDEX_W, 3, log2(NUM_SETS)
TAG_W, 25, equals 28 - INDEX_W; tag = pc[31:4+INDEX_W]

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
read  input  1  fetch request from IF stage
pc  input  32  byte address of the fetch; pc[1:0] ignored
instruction  output  32  fetched word; valid when read=1 and busywait=0
busywait  output  1  stall request to the pipeline
mem_read  output  1  block read request to instruction memory
mem_address  output  28  block address, equals {tag,index} of the missing line
mem_readdata  input  128  returned block; byte 0 is in [7:0], word k is in [32k+31:32k]
mem_busywait  input  1  memory busy; falls when mem_readdata is valid

Behaviour:
- Reset (async, active-high):
  - state returns to IDLE; all valid bits are cleared.
  - mem_read=0, mem_address=0, busywait=0, miss counter cleared.
  - Data and tag arrays are not cleared.
- Address split: offset=pc[3:2] selects the word, index=pc[4+INDEX_W-1:4], tag=pc[31:4+INDEX_W].
- hit = valid[index] && tag_array[index]==tag. This is combinational.
- instruction = data_array[index] word[offset] when hit, else 32'h0. This is combinational, with zero added cycles.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE:
    - read=1 and hit: busywait=0; no memory activity.
    - read=1 and miss: busywait=1 in the same cycle (combinational). At posedge, latch miss_addr=pc[31:4] and go to MEM_READ.
    - read=0: busywait=0 and state holds.
  - MEM_READ:
    - mem_read=1, mem_address=miss_addr (from latch), busywait=1.
    - The cache samples mem_busywait at each posedge. The first posedge after entry is ignored, which guarantees memory has seen read high.
    - From the second posedge on, mem_busywait=0 -> capture mem_readdata and go to UPDATE.
  - UPDATE:
    - Write data_array[miss index]=captured block, tag_array=miss tag, valid=1.
    - mem_read=0, busywait=1.
    - Next state IDLE.
- Latency: a miss costs entry cycle + memory time + 1 UPDATE cycle. The hit appears combinationally in the first IDLE cycle after UPDATE.
- pc changes while in MEM_READ/UPDATE are ignored. The fill always uses miss_addr. Back in IDLE, the current pc is re-evaluated and may miss again.
- read dropping mid-miss does not abort the fill; the line is still installed.
- mem_read is only asserted in MEM_READ and is never held across two different misses; at least one cycle low between fills.
- Reset mid-MEM_READ: mem_read and busywait drop immediately and the line is not installed. The first read after reset misses.
- Conflict: a new tag at an occupied index overwrites the line. There is no write-back; the cache is read-only.
- miss_count (internal, 16-bit, wraps) increments on each IDLE->MEM_READ transition. It is exposed for simulation only via hierarchical reference.

Decomposition:
- Shared package `icache_pkg`:
  - state encoding constants (IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2)
  - BLOCK_W=128, WORD_W=32, MEM_ADDR_W=28
  - offset/index/tag field positions
- One natural sub-module, `icache_line_store`:
  - valid/tag/data arrays with async clear of valid
  - combinational hit/word select
  - one write port used by UPDATE
- The FSM and miss latch stay in `icache_controller`.

Test Plan:
- Memory model image: word0=32'h00500093, word1=32'h00506113, word2=32'h002081B3, word3=32'h00302223. Bench memory model: busywait rises with read, falls 4 cycles later with the block.
- Cold miss: reset, read=1, pc=0 -> busywait=1 same cycle; next cycle mem_read=1, mem_address=28'h0; after fill and UPDATE, busywait=0, instruction=32'h00500093, miss_count=1.
- Same-line hits: after the cold miss, pc=4, 8, C on consecutive cycles -> 32'h00506113, 32'h002081B3, 32'h00302223; busywait=0, mem_read never asserted.
- Conflict eviction: pc=32'h80 -> miss, mem_address=28'h0000008, index 0 refilled. Then pc=0 -> miss again with mem_address=28'h0; miss_count=3.
- pc change mid-miss: miss on pc=32'h10, then set pc=0 during MEM_READ -> mem_address stays 28'h1 and line 1 is filled. On return to IDLE, pc=0 is evaluated as its own hit or miss.
- Reset mid-fill: assert reset two cycles into MEM_READ -> mem_read=0 and busywait=0 immediately. After release, pc=0 misses again (valid cleared).
- Idle: read=0 with random pc -> busywait=0, mem_read=0 for 20 cycles.
